// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback bundle between the ALU/load sources, the arbiter and the
// register file write port (WE3/A3/WD3). It also carries the PC redirect
// outputs and the hazard view (busy_mask, fifo_count) used by decode.
interface regfile_writeback_arbiter_if #(
  parameter int N     = 4,
  parameter int M     = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // ALU result source
  logic              alu_valid;
  logic              alu_ready;
  logic [N-1:0]      alu_addr;
  logic [M-1:0]      alu_data;

  // Load issue and load return
  logic              ld_issue;
  logic [N-1:0]      ld_issue_addr;
  logic              ld_valid;
  logic [N-1:0]      ld_dest;
  logic [M-1:0]      ld_data;

  // Register file write port and PC redirect
  logic              WE3;
  logic [N-1:0]      A3;
  logic [M-1:0]      WD3;
  logic              pc_wr_valid;
  logic [M-1:0]      pc_wr_data;

  // Hazard tracking for decode
  logic [2**N-1:0]   busy_mask;
  logic [CW-1:0]     fifo_count;

  // Pipeline side: offers results and loads, observes writes and hazards
  modport master (
    output alu_valid, alu_addr, alu_data,
    output ld_issue, ld_issue_addr, ld_valid, ld_dest, ld_data,
    input  alu_ready,
    input  WE3, A3, WD3, pc_wr_valid, pc_wr_data,
    input  busy_mask, fifo_count
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ld_issue, ld_issue_addr, ld_valid, ld_dest, ld_data,
    output alu_ready,
    output WE3, A3, WD3, pc_wr_valid, pc_wr_data,
    output busy_mask, fifo_count
  );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU results and returning load data onto the single register file
// write port. Loads win every cycle; ALU results that lose wait in a small
// in-order FIFO. Writes to the top register (the PC) become a one-cycle
// pc_wr_valid pulse instead of a register file write. busy_mask reports every
// destination that still has a write pending so decode can stall.
module regfile_writeback_arbiter #(
  parameter int N     = 4,
  parameter int M     = 32,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  regfile_writeback_arbiter_if.slave    wb
);

  localparam int             AW      = $clog2(DEPTH);
  localparam int             CW      = AW + 1;
  localparam int             NREG    = 2**N;
  localparam logic [N-1:0]   PC_ADDR = '1;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_LOAD,
    GNT_FIFO,
    GNT_BYPASS
  } grant_e;

  // FIFO storage and bookkeeping
  logic [N-1:0]    fifo_addr_q [DEPTH];
  logic [M-1:0]    fifo_data_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  // Destinations of loads issued but not yet returned
  logic [NREG-1:0] ld_pend_q, ld_pend_d;

  // Registered write port
  logic            we3_q,      we3_d;
  logic [N-1:0]    a3_q,       a3_d;
  logic [M-1:0]    wd3_q,      wd3_d;
  logic            pc_valid_q, pc_valid_d;
  logic [M-1:0]    pc_data_q,  pc_data_d;

  // Arbitration results
  grant_e          grant;
  logic [N-1:0]    gnt_addr;
  logic [M-1:0]    gnt_data;
  logic            alu_ready;
  logic            push;
  logic            pop;
  logic [NREG-1:0] busy;
  logic [AW-1:0]   slot_off;

  // Fixed-priority grant: load return, then FIFO head, then ALU bypass
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    grant     = GNT_IDLE;
    gnt_addr  = wb.ld_dest;
    gnt_data  = wb.ld_data;
    alu_ready = (count_q < CW'(DEPTH));
    if (wb.ld_valid) begin
      grant = GNT_LOAD;
    end else if (count_q != '0) begin
      grant    = GNT_FIFO;
      gnt_addr = fifo_addr_q[rd_ptr_q];
      gnt_data = fifo_data_q[rd_ptr_q];
    end else if (wb.alu_valid) begin
      grant    = GNT_BYPASS;
      gnt_addr = wb.alu_addr;
      gnt_data = wb.alu_data;
    end
    // An accepted ALU result that did not go straight out is queued
    push = wb.alu_valid && alu_ready && (grant != GNT_BYPASS);
    pop  = (grant == GNT_FIFO);
  end

  // FIFO pointer and occupancy next state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Outstanding-load tracking: a new issue wins over a same-cycle return
  always_comb begin
    ld_pend_d = ld_pend_q;
    // NOTE: blocking assignments here are evaluated in order, so the later set overrides the earlier clear.
    if (wb.ld_valid) ld_pend_d[wb.ld_dest]       = 1'b0;
    if (wb.ld_issue) ld_pend_d[wb.ld_issue_addr] = 1'b1;
  end

  // Next write-port values: PC writes pulse pc_wr_valid, others drive WE3
  always_comb begin
    we3_d      = 1'b0;
    pc_valid_d = 1'b0;
    a3_d       = a3_q;
    wd3_d      = wd3_q;
    pc_data_d  = pc_data_q;
    if (grant != GNT_IDLE) begin
      if (gnt_addr == PC_ADDR) begin
        pc_valid_d = 1'b1;
        pc_data_d  = gnt_data;
      end else begin
        we3_d = 1'b1;
        a3_d  = gnt_addr;
        wd3_d = gnt_data;
      end
    end
  end

  // Hazard view: outstanding loads plus the destination of every queued entry
  always_comb begin
    busy     = ld_pend_q;
    slot_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = AW'(i) - rd_ptr_q;
      if (CW'(slot_off) < count_q) busy[fifo_addr_q[i]] = 1'b1;
    end
  end

  // Control and output state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ld_pend_q  <= '0;
      we3_q      <= 1'b0;
      a3_q       <= '0;
      wd3_q      <= '0;
      pc_valid_q <= 1'b0;
      pc_data_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ld_pend_q  <= ld_pend_d;
      we3_q      <= we3_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
      pc_valid_q <= pc_valid_d;
      pc_data_q  <= pc_data_d;
    end
  end

  // FIFO storage writes
  // NOTE: the storage array has no reset; an entry is only ever read or decoded while count marks it valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wb.alu_addr;
      fifo_data_q[wr_ptr_q] <= wb.alu_data;
    end
  end

  assign wb.alu_ready   = alu_ready;
  assign wb.WE3         = we3_q;
  assign wb.A3          = a3_q;
  assign wb.WD3         = wd3_q;
  assign wb.pc_wr_valid = pc_valid_q;
  assign wb.pc_wr_data  = pc_data_q;
  assign wb.busy_mask   = busy;
  assign wb.fifo_count  = count_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: a table of directed
// vectors, hand-written backpressure and reset-abort sequences, and a
// randomized run scored against a queue-based reference model.
module tb_regfile_writeback_arbiter;

  localparam int N     = 4;
  localparam int M     = 32;
  localparam int DEPTH = 4;
  localparam int NV    = 13;

  logic clk;
  logic reset;

  regfile_writeback_arbiter_if #(.N(N), .M(M), .DEPTH(DEPTH)) wb ();

  regfile_writeback_arbiter #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [3:0]  aa;
    logic [31:0] ad;
    logic        li;
    logic [3:0]  lia;
    logic        lv;
    logic [3:0]  ldst;
    logic [31:0] ldd;
    logic        e_ready;
    logic        e_we;
    logic [3:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_pcv;
    logic [31:0] e_pcd;
    logic [15:0] e_busy;
    logic [2:0]  e_cnt;
  } vec_t;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } ent_t;

  vec_t        tbl [NV];
  int          n_checks;
  int          n_fail;

  // backpressure sequence bookkeeping
  int          next_alu;
  logic        rdy;
  logic        offered;
  logic [3:0]  got_a [$];
  logic [31:0] got_d [$];

  // reference model state
  ent_t        mq [$];
  ent_t        e;
  logic [15:0] m_pend;
  logic [15:0] m_busy;
  logic        m_we, m_pcv, m_have, m_bypass;
  logic [3:0]  m_a3, g_a;
  logic [31:0] m_wd, m_pcd, g_d;
  logic        r_av, r_li, r_lv;
  logic [3:0]  r_aa, r_lia, r_ld;
  logic [31:0] r_ad, r_ldd;
  logic        r_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                       input logic li, input logic [3:0] lia,
                       input logic lv, input logic [3:0] ldst, input logic [31:0] ldd);
    wb.alu_valid     = av;
    wb.alu_addr      = aa;
    wb.alu_data      = ad;
    wb.ld_issue      = li;
    wb.ld_issue_addr = lia;
    wb.ld_valid      = lv;
    wb.ld_dest       = ldst;
    wb.ld_data       = ldd;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                              input logic li, input logic [3:0] lia,
                              input logic lv, input logic [3:0] ldst, input logic [31:0] ldd,
                              input logic er, input logic ew, input logic [3:0] ea,
                              input logic [31:0] ewd, input logic epv, input logic [31:0] epd,
                              input logic [15:0] eb, input logic [2:0] ec);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.li = li; v.lia = lia;
    v.lv = lv; v.ldst = ldst; v.ldd = ldd;
    v.e_ready = er; v.e_we = ew; v.e_a3 = ea; v.e_wd = ewd;
    v.e_pcv = epv; v.e_pcd = epd; v.e_busy = eb; v.e_cnt = ec;
    return v;
  endfunction

  // Hard stop in case the run ever stalls
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;

    //            alu           ld_issue  ld_valid        rdy  we a3 wd        pcv pcd       busy     cnt
    tbl[0]  = mk(0, 0,  0,      0, 0,     0, 0, 0,        1,   0, 0, 0,        0, 0,        16'h0000, 0);
    tbl[1]  = mk(1, 3,  'h11,   0, 0,     0, 0, 0,        1,   1, 3, 'h11,     0, 0,        16'h0000, 0);
    tbl[2]  = mk(0, 0,  0,      0, 0,     0, 0, 0,        1,   0, 3, 'h11,     0, 0,        16'h0000, 0);
    tbl[3]  = mk(1, 2,  'h22,   0, 0,     1, 5, 'hAA,     1,   1, 5, 'hAA,     0, 0,        16'h0004, 1);
    tbl[4]  = mk(0, 0,  0,      0, 0,     0, 0, 0,        1,   1, 2, 'h22,     0, 0,        16'h0000, 0);
    tbl[5]  = mk(1, 15, 'h1000, 0, 0,     0, 0, 0,        1,   0, 2, 'h22,     1, 'h1000,   16'h0000, 0);
    tbl[6]  = mk(0, 0,  0,      0, 0,     0, 0, 0,        1,   0, 2, 'h22,     0, 'h1000,   16'h0000, 0);
    tbl[7]  = mk(0, 0,  0,      1, 7,     0, 0, 0,        1,   0, 2, 'h22,     0, 'h1000,   16'h0080, 0);
    tbl[8]  = mk(0, 0,  0,      1, 7,     1, 7, 'h77,     1,   1, 7, 'h77,     0, 'h1000,   16'h0080, 0);
    tbl[9]  = mk(0, 0,  0,      0, 0,     1, 7, 'h78,     1,   1, 7, 'h78,     0, 'h1000,   16'h0000, 0);
    tbl[10] = mk(0, 0,  0,      0, 0,     1, 9, 'h99,     1,   1, 9, 'h99,     0, 'h1000,   16'h0000, 0);
    tbl[11] = mk(0, 0,  0,      0, 0,     1, 15, 'hBEEF,  1,   0, 9, 'h99,     1, 'hBEEF,   16'h0000, 0);
    tbl[12] = mk(0, 0,  0,      0, 0,     0, 0, 0,        1,   0, 9, 'h99,     0, 'hBEEF,   16'h0000, 0);

    // ---------------- reset state ----------------
    do_reset();
    check("reset WE3",         wb.WE3,         0);
    check("reset A3",          wb.A3,          0);
    check("reset WD3",         wb.WD3,         0);
    check("reset pc_wr_valid", wb.pc_wr_valid, 0);
    check("reset busy_mask",   wb.busy_mask,   0);
    check("reset alu_ready",   wb.alu_ready,   1);
    check("reset fifo_count",  wb.fifo_count,  0);

    // ---------------- directed table ----------------
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].li, tbl[i].lia,
            tbl[i].lv, tbl[i].ldst, tbl[i].ldd);
      #1;
      check($sformatf("vec%0d alu_ready", i), wb.alu_ready, tbl[i].e_ready);
      tick();
      check($sformatf("vec%0d WE3", i),         wb.WE3,         tbl[i].e_we);
      check($sformatf("vec%0d A3", i),          wb.A3,          tbl[i].e_a3);
      check($sformatf("vec%0d WD3", i),         wb.WD3,         tbl[i].e_wd);
      check($sformatf("vec%0d pc_wr_valid", i), wb.pc_wr_valid, tbl[i].e_pcv);
      check($sformatf("vec%0d pc_wr_data", i),  wb.pc_wr_data,  tbl[i].e_pcd);
      check($sformatf("vec%0d busy_mask", i),   wb.busy_mask,   tbl[i].e_busy);
      check($sformatf("vec%0d fifo_count", i),  wb.fifo_count,  tbl[i].e_cnt);
    end

    // ---------------- loads hold the port while ALU offers r1..r6 ----------------
    idle();
    next_alu = 1;
    for (int c = 0; c < 14; c++) begin
      offered = (next_alu <= 6);
      drive(offered, 4'(next_alu), 32'h100 + 32'(next_alu), 1'b0, 4'd0,
            (c < 6), 4'd8, 32'h800 + 32'(c));
      #1;
      rdy = wb.alu_ready;
      if (c < 4)           check($sformatf("bp cyc%0d ready high", c), rdy, 1);
      if (c == 4 || c == 5) check($sformatf("bp cyc%0d ready low", c), rdy, 0);
      if (c == 6)          check("bp full before drain", wb.fifo_count, 4);
      if (c == 6)          check("bp busy while full", wb.busy_mask, 16'h001E);
      tick();
      if (offered && rdy) next_alu++;
      if (c < 6) begin
        check($sformatf("bp cyc%0d load A3", c),  wb.A3,  8);
        check($sformatf("bp cyc%0d load WD3", c), wb.WD3, 32'h800 + 32'(c));
      end else if (wb.WE3) begin
        got_a.push_back(wb.A3);
        got_d.push_back(wb.WD3);
      end
    end
    check("bp drained count", wb.fifo_count, 0);
    check("bp write total", got_a.size(), 6);
    for (int k = 0; k < 6 && k < got_a.size(); k++) begin
      check($sformatf("bp order%0d A3", k),  got_a[k], k + 1);
      check($sformatf("bp order%0d WD3", k), got_d[k], 32'h100 + 32'(k + 1));
    end

    // ---------------- reset with a pending load and three queued writes ----------------
    idle();
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'(c + 1), 32'h300 + 32'(c), 1'b0, 4'd0, 1'b1, 4'd12, 32'hC00);
      tick();
    end
    check("abort pre count", wb.fifo_count, 3);
    check("abort pre busy",  wb.busy_mask,  16'h008E);
    idle();
    #2;
    reset = 1'b1;
    #1;
    check("abort async WE3",   wb.WE3,        0);
    check("abort async count", wb.fifo_count, 0);
    check("abort async busy",  wb.busy_mask,  0);
    check("abort async ready", wb.alu_ready,  1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("abort post WE3",   wb.WE3,         0);
    check("abort post pcv",   wb.pc_wr_valid, 0);
    check("abort post count", wb.fifo_count,  0);
    check("abort post busy",  wb.busy_mask,   0);

    // ---------------- randomized run against the reference model ----------------
    do_reset();
    mq.delete();
    m_pend = '0;
    m_a3   = '0;
    m_wd   = '0;
    m_pcd  = '0;
    r_av   = 1'b0;
    r_aa   = '0;
    r_ad   = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // An ALU offer that was refused is held; otherwise a fresh random one
      if (!r_av) begin
        r_av = ($urandom_range(0, 2) != 0);
        r_aa = 4'($urandom_range(0, 15));
        r_ad = $urandom;
      end
      r_li  = ($urandom_range(0, 3) == 0);
      r_lia = 4'($urandom_range(0, 15));
      r_lv  = ($urandom_range(0, 2) == 0);
      r_ld  = 4'($urandom_range(0, 15));
      r_ldd = $urandom;
      drive(r_av, r_aa, r_ad, r_li, r_lia, r_lv, r_ld, r_ldd);
      #1;

      r_ready = (mq.size() < DEPTH);
      m_busy  = m_pend;
      foreach (mq[k]) m_busy[mq[k].a] = 1'b1;
      check($sformatf("rnd%0d alu_ready", cyc),  wb.alu_ready,  r_ready);
      check($sformatf("rnd%0d fifo_count", cyc), wb.fifo_count, mq.size());
      check($sformatf("rnd%0d busy_mask", cyc),  wb.busy_mask,  m_busy);

      m_have   = 1'b0;
      m_bypass = 1'b0;
      g_a      = '0;
      g_d      = '0;
      if (r_lv) begin
        m_have = 1'b1;
        g_a    = r_ld;
        g_d    = r_ldd;
      end else if (mq.size() > 0) begin
        e      = mq.pop_front();
        m_have = 1'b1;
        g_a    = e.a;
        g_d    = e.d;
      end else if (r_av) begin
        m_have   = 1'b1;
        m_bypass = 1'b1;
        g_a      = r_aa;
        g_d      = r_ad;
      end
      if (r_av && r_ready && !m_bypass) begin
        e.a = r_aa;
        e.d = r_ad;
        mq.push_back(e);
      end
      if (r_lv) m_pend[r_ld]  = 1'b0;
      if (r_li) m_pend[r_lia] = 1'b1;
      m_we  = 1'b0;
      m_pcv = 1'b0;
      if (m_have) begin
        if (g_a == 4'd15) begin
          m_pcv = 1'b1;
          m_pcd = g_d;
        end else begin
          m_we = 1'b1;
          m_a3 = g_a;
          m_wd = g_d;
        end
      end
      if (r_av && r_ready) r_av = 1'b0;

      tick();
      check($sformatf("rnd%0d WE3", cyc),         wb.WE3,         m_we);
      check($sformatf("rnd%0d A3", cyc),          wb.A3,          m_a3);
      check($sformatf("rnd%0d WD3", cyc),         wb.WD3,         m_wd);
      check($sformatf("rnd%0d pc_wr_valid", cyc), wb.pc_wr_valid, m_pcv);
      check($sformatf("rnd%0d pc_wr_data", cyc),  wb.pc_wr_data,  m_pcd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
